// File: rtl/ark_pkg.sv
// Shared types and sizing for the byte-serial AddRoundKey stream stage.
package ark_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    XOR  = 1'b1
  } ark_state_t;

  localparam int ARK_DATA_W = 8;
  localparam int ARK_NBYTES = 16;

  function automatic int ark_cnt_w(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage

// File: rtl/ark_load_buf.sv
// Write-pointer block buffer: accepts NBYTES words, then holds them for indexed reads until cleared.
// Ready drops once full; clear rewinds the pointer so the next block can load.
module ark_load_buf
  import ark_pkg::*;
#(
  parameter  int DATA_W = ARK_DATA_W,
  parameter  int NBYTES = ARK_NBYTES,
  localparam int CNT_W  = ark_cnt_w(NBYTES),
  localparam int IDX_W  = $clog2(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  output logic              ready,
  output logic              full,
  input  logic              clear,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] dout
);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [NBYTES];

  assign full  = (cnt == CNT_W'(NBYTES));
  assign ready = !full;
  assign dout  = mem[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (valid && ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Contents are don't-care after reset; only the pointer matters.
  always_ff @(posedge clk) begin
    if (valid && ready) begin
      mem[cnt[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/add_round_key_stream.sv
// Byte-serial AES AddRoundKey: loads a state block and a key block, then streams state^key with last flag.
// First word 2 cycles after final load; holds under dout_ready=0. ARK_KEY_HOLD_EN keeps the key across blocks.
module add_round_key_stream
  import ark_pkg::*;
#(
  parameter  int DATA_W = ARK_DATA_W,
  parameter  int NBYTES = ARK_NBYTES,
  localparam int IDX_W  = $clog2(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ARK_KEY_HOLD_EN
  input  logic              key_flush,
`endif
  input  logic [DATA_W-1:0] col_din,
  input  logic              col_valid,
  output logic              col_ready,
  input  logic [DATA_W-1:0] key_din,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy
);

  ark_state_t        state, state_nxt;
  logic [IDX_W-1:0]  cz, rd_idx;
  logic              col_full, key_full;
  logic              col_clear, key_clear;
  logic              fire, at_last;
  logic [DATA_W-1:0] col_word, key_word;

  ark_load_buf #(.DATA_W(DATA_W), .NBYTES(NBYTES)) u_col_buf (
    .clk   (clk),
    .rst   (rst),
    .din   (col_din),
    .valid (col_valid),
    .ready (col_ready),
    .full  (col_full),
    .clear (col_clear),
    .idx   (rd_idx),
    .dout  (col_word)
  );

  ark_load_buf #(.DATA_W(DATA_W), .NBYTES(NBYTES)) u_key_buf (
    .clk   (clk),
    .rst   (rst),
    .din   (key_din),
    .valid (key_valid),
    .ready (key_ready),
    .full  (key_full),
    .clear (key_clear),
    .idx   (rd_idx),
    .dout  (key_word)
  );

  assign fire    = dout_valid && dout_ready;
  assign at_last = (cz == IDX_W'(NBYTES - 1));
  // Read the word that will be presented after this edge, so the output register stays one per cycle.
  assign rd_idx  = (fire && !at_last) ? cz + IDX_W'(1) : cz;
  assign busy    = (state == XOR);

  always_comb begin
    state_nxt = state;
    col_clear = 1'b0;
    key_clear = 1'b0;
    case (state)
      LOAD: begin
        if (col_full && key_full) state_nxt = XOR;
      end
      XOR: begin
        if (fire && at_last) begin
          state_nxt = LOAD;
          col_clear = 1'b1;
`ifndef ARK_KEY_HOLD_EN
          key_clear = 1'b1;
`endif
        end
      end
      default: state_nxt = LOAD;
    endcase
`ifdef ARK_KEY_HOLD_EN
    if (key_flush && state == LOAD) key_clear = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cz         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (state == XOR) begin
      if (!dout_valid) begin
        dout       <= col_word ^ key_word;
        dout_valid <= 1'b1;
        dout_last  <= (rd_idx == IDX_W'(NBYTES - 1));
      end else if (fire) begin
        if (at_last) begin
          cz         <= '0;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
        end else begin
          cz         <= rd_idx;
          dout       <= col_word ^ key_word;
          dout_last  <= (rd_idx == IDX_W'(NBYTES - 1));
        end
      end
    end
  end

endmodule
